// File: rtl/cic3_decimator.sv
// cic3_decimator: sinc3 decimator turning a 1-bit modulator stream into unsigned OUT_W-bit words.
module cic3_decimator #(
    parameter int DEC   = 512,
    parameter int ACC_W = 28,
    parameter int OUT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mod_in,
    input  logic             mod_valid,
    output logic [OUT_W-1:0] data_out,
    output logic             load
);
    localparam int CW = $clog2(DEC);
    localparam logic [CW-1:0] LAST = CW'(DEC - 1);

    typedef enum logic [2:0] {IDLE, SNAP, COMB1, COMB2, COMB3} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             tick;
    logic [ACC_W-1:0] i1, i2, i3;
    logic [ACC_W-1:0] s, s_d, c1, c1_d, c2, c2_d;
    logic [ACC_W-1:0] c3;
    logic             sat;

    assign c3  = c2 - c2_d;
    // Only the all-ones input reaches DEC^3, which needs one bit more than the output.
    assign sat = |c3[ACC_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            tick     <= 1'b0;
            i1       <= '0;
            i2       <= '0;
            i3       <= '0;
            s        <= '0;
            s_d      <= '0;
            c1       <= '0;
            c1_d     <= '0;
            c2       <= '0;
            c2_d     <= '0;
            data_out <= '0;
            load     <= 1'b0;
        end else begin
            tick <= mod_valid && cnt == LAST;
            load <= 1'b0;
            if (mod_valid) begin
                i1  <= i1 + {{(ACC_W-1){1'b0}}, mod_in};
                i2  <= i2 + i1;
                i3  <= i3 + i2;
                cnt <= cnt + 1'b1;
            end
            case (state)
                IDLE:  state <= tick ? SNAP : IDLE;
                SNAP: begin
                    s     <= i3;
                    state <= COMB1;
                end
                COMB1: begin
                    c1    <= s - s_d;
                    s_d   <= s;
                    state <= COMB2;
                end
                COMB2: begin
                    c2    <= c1 - c1_d;
                    c1_d  <= c1;
                    state <= COMB3;
                end
                COMB3: begin
                    c2_d     <= c2;
                    data_out <= sat ? '1 : c3[OUT_W-1:0];
                    load     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cic3_decimator.sv
// tb_cic3_decimator: directed checks of the sinc3 decimator against hand values and a per-strobe model.
module tb_cic3_decimator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mod_in = 1'b0;
    logic        mod_valid = 1'b0;
    logic [26:0] data_out;
    logic        load;

    int pass_cnt = 0;
    int total_cnt = 0;

    cic3_decimator dut (
        .clk(clk),
        .rst(rst),
        .mod_in(mod_in),
        .mod_valid(mod_valid),
        .data_out(data_out),
        .load(load)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [26:0] got_val[$];
    int          got_cyc[$];
    logic [26:0] exp_val[$];
    int          exp_cyc[$];
    int          wide = 0;
    logic        load_q = 1'b0;

    always @(negedge clk) begin
        if (load === 1'b1) begin
            got_val.push_back(data_out);
            got_cyc.push_back(cyc);
        end
        if (load === 1'b1 && load_q === 1'b1) wide++;
        load_q = load;
    end

    logic [27:0] m_i1, m_i2, m_i3, m_s, m_sd, m_c1, m_c1d, m_c2, m_c2d, m_c3;
    int m_cnt;

    task model_reset();
        m_i1 = '0; m_i2 = '0; m_i3 = '0; m_sd = '0; m_c1d = '0; m_c2d = '0;
        m_cnt = 0;
        got_val.delete(); got_cyc.delete(); exp_val.delete(); exp_cyc.delete();
        wide = 0;
    endtask

    task model_step(input logic b, input int c);
        m_i3 = m_i3 + m_i2;
        m_i2 = m_i2 + m_i1;
        m_i1 = m_i1 + {27'd0, b};
        m_cnt++;
        if (m_cnt == 512) begin
            m_cnt = 0;
            m_s   = m_i3;
            m_c1  = m_s - m_sd;   m_sd  = m_s;
            m_c2  = m_c1 - m_c1d; m_c1d = m_c1;
            m_c3  = m_c2 - m_c2d; m_c2d = m_c2;
            exp_val.push_back(m_c3[27] ? 27'h7FFFFFF : m_c3[26:0]);
            exp_cyc.push_back(c + 5);
        end
    endtask

    task do_reset();
        @(negedge clk);
        rst = 1'b1;
        mod_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task strobe(input logic b, input int gap);
        mod_in = b;
        mod_valid = 1'b1;
        @(negedge clk);
        mod_valid = 1'b0;
        model_step(b, cyc);
        repeat (gap - 1) @(negedge clk);
    endtask

    task settle();
        repeat (12) @(negedge clk);
    endtask

    task test_reset();
        do_reset();
        repeat (300) strobe(1'b1, 2);
        rst = 1'b1;
        mod_in = 1'b1;
        mod_valid = 1'b1;
        @(negedge clk);
        mod_valid = 1'b0;
        @(negedge clk);
        mod_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mod_valid = 1'b0;
        model_reset();
        @(negedge clk);
        total_cnt++;
        if (data_out !== 27'd0) $display("FAIL reset_data_out got %h want 0", data_out); else pass_cnt++;
        total_cnt++;
        if (load !== 1'b0) $display("FAIL reset_load got %b want 0", load); else pass_cnt++;
        repeat (511) strobe(1'b1, 2);
        settle();
        total_cnt++;
        if (got_cyc.size() != 0) $display("FAIL reset_early_load got %0d loads want 0", got_cyc.size()); else pass_cnt++;
        strobe(1'b1, 2);
        settle();
        total_cnt++;
        if (got_cyc.size() != 1) $display("FAIL reset_first_load got %0d loads want 1", got_cyc.size()); else pass_cnt++;
        total_cnt++;
        if (got_cyc.size() < 1 || got_cyc[0] != exp_cyc[0])
            $display("FAIL reset_latency got cyc %0d want %0d", got_cyc.size() ? got_cyc[0] : -1, exp_cyc[0]);
        else pass_cnt++;
        total_cnt++;
        if (got_val.size() < 1 || got_val[0] !== exp_val[0])
            $display("FAIL reset_first_value got %h want %h", got_val.size() ? got_val[0] : 27'h0, exp_val[0]);
        else pass_cnt++;
    endtask

    task test_zeros();
        do_reset();
        repeat (2048) strobe(1'b0, 2);
        settle();
        total_cnt++;
        if (got_val.size() != 4) $display("FAIL zeros_count got %0d want 4", got_val.size()); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (k >= got_val.size() || got_val[k] !== 27'd0)
                $display("FAIL zeros_value[%0d] got %h want 0", k, k < got_val.size() ? got_val[k] : 27'h0);
            else pass_cnt++;
            total_cnt++;
            if (k >= got_cyc.size() || got_cyc[k] != exp_cyc[k])
                $display("FAIL zeros_latency[%0d] got %0d want %0d", k, k < got_cyc.size() ? got_cyc[k] : -1, exp_cyc[k]);
            else pass_cnt++;
        end
        total_cnt++;
        if (wide != 0) $display("FAIL zeros_load_width got %0d wide pulses want 0", wide); else pass_cnt++;
    endtask

    task test_ones();
        do_reset();
        repeat (2560) strobe(1'b1, 2);
        settle();
        total_cnt++;
        if (got_val.size() != 5) $display("FAIL ones_count got %0d want 5", got_val.size()); else pass_cnt++;
        for (int k = 3; k < 5; k++) begin
            total_cnt++;
            if (k >= got_val.size() || got_val[k] !== 27'h7FFFFFF)
                $display("FAIL ones_value[%0d] got %h want 7ffffff", k, k < got_val.size() ? got_val[k] : 27'h0);
            else pass_cnt++;
        end
        total_cnt++;
        if (wide != 0) $display("FAIL ones_load_width got %0d wide pulses want 0", wide); else pass_cnt++;
    endtask

    task test_alternating();
        do_reset();
        for (int i = 0; i < 2560; i++) strobe((i % 2) == 0, 2);
        settle();
        total_cnt++;
        if (got_val.size() != 5) $display("FAIL alt_count got %0d want 5", got_val.size()); else pass_cnt++;
        for (int k = 3; k < 5; k++) begin
            total_cnt++;
            if (k >= got_val.size() || got_val[k] !== 27'h4000000)
                $display("FAIL alt_value[%0d] got %h want 4000000", k, k < got_val.size() ? got_val[k] : 27'h0);
            else pass_cnt++;
        end
    endtask

    task test_spacing();
        do_reset();
        for (int i = 0; i < 1536; i++) strobe((i % 3) != 2, 2);
        for (int i = 1536; i < 2560; i++) strobe((i % 3) != 2, 37);
        settle();
        total_cnt++;
        if (got_val.size() != 5) $display("FAIL spacing_count got %0d want 5", got_val.size()); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if (k >= got_val.size() || got_val[k] !== exp_val[k])
                $display("FAIL spacing_value[%0d] got %h want %h", k, k < got_val.size() ? got_val[k] : 27'h0, exp_val[k]);
            else pass_cnt++;
            total_cnt++;
            if (k >= got_cyc.size() || got_cyc[k] != exp_cyc[k])
                $display("FAIL spacing_latency[%0d] got %0d want %0d", k, k < got_cyc.size() ? got_cyc[k] : -1, exp_cyc[k]);
            else pass_cnt++;
        end
    endtask

    task test_reset_mid_comb();
        int c;
        do_reset();
        repeat (512) strobe(1'b1, 2);
        c = exp_cyc[0] - 5;
        for (int t = 0; t < 10 && cyc != c + 3; t++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        settle();
        total_cnt++;
        if (got_val.size() != 0) $display("FAIL midcomb_aborted got %0d loads want 0", got_val.size()); else pass_cnt++;
        model_reset();
        repeat (512) strobe(1'b0, 2);
        settle();
        total_cnt++;
        if (got_val.size() != 1) $display("FAIL midcomb_next_count got %0d want 1", got_val.size()); else pass_cnt++;
        total_cnt++;
        if (got_val.size() < 1 || got_val[0] !== 27'd0)
            $display("FAIL midcomb_next_value got %h want 0", got_val.size() ? got_val[0] : 27'h0);
        else pass_cnt++;
        total_cnt++;
        if (got_cyc.size() < 1 || got_cyc[0] != exp_cyc[0])
            $display("FAIL midcomb_latency got %0d want %0d", got_cyc.size() ? got_cyc[0] : -1, exp_cyc[0]);
        else pass_cnt++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_zeros();
        test_ones();
        test_alternating();
        test_spacing();
        test_reset_mid_comb();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/cic3_decimator.md
Name: cic3_decimator

Overview:
- Third-order CIC (sinc3) decimation filter that turns the 1-bit delta-sigma modulator bitstream into 27-bit output words.
- Sits directly upstream of the SPI readout shift register. Its data_out and load drive that register's data_in and load inputs.
- Integrators run at the modulator sample rate, gated by mod_valid. Combs run once per decimated sample in a short multi-cycle sequence.

Parameters:
- DEC, 512, decimation ratio; power of two, 8..512.
- ACC_W, 28, internal integrator/comb width; must equal 3*log2(DEC)+1.
- OUT_W, 27, output word width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- mod_in  input  1  modulator bit, 1 = +full-scale, 0 = zero; unsigned 0/1 input
- mod_valid  input  1  one-cycle strobe; mod_in is sampled only when high; consecutive strobes at least 2 clk apart
- data_out  output  OUT_W  latest decimated sample, unsigned; held between updates
- load  output  1  one-cycle pulse in the cycle data_out changes

Behaviour:
- Reset: synchronous, active-high (rst sampled on posedge clk).
  - Clears all integrators, comb delay registers, the decimation counter and the FSM (to IDLE).
  - data_out = 0, load = 0.
  - A reset mid-window or mid-comb-sequence aborts it; no load pulse is issued for that window.
- Integrators: all ACC_W bits, two's-complement wrap-around (modular) arithmetic, no saturation. Update only when mod_valid = 1:
  - i1 <= i1 + mod_in
  - i2 <= i2 + i1 (old value)
  - i3 <= i3 + i2 (old value)
  - Pipelined chain; its 2-sample group delay is accepted.
- Decimation counter: 0..DEC-1, increments on mod_valid, wraps to 0. A mod_valid seen with counter = DEC-1 raises an internal tick, registered one cycle later.
- FSM states: IDLE, SNAP, COMB1, COMB2, COMB3. One state per clk, no stalls.
  - IDLE -> SNAP on tick.
  - SNAP: s <= i3, i.e. the value including the window's final integrator update. A mod_valid in this same cycle must not affect the snapshot.
  - COMB1: c1 <= s - s_d; s_d <= s.
  - COMB2: c2 <= c1 - c1_d; c1_d <= c1.
  - COMB3: c3 <= c2 - c2_d; c2_d <= c2. Also registers data_out, pulses load = 1, returns to IDLE.
  - Every comb subtraction is ACC_W-bit modular.
  - Integrators keep accumulating during SNAP..COMB3.
- Latency: mod_valid completing a window at cycle n -> load = 1 in cycle n+5, for exactly one cycle.
- Output range: exact result lies in 0..DEC^3 (= 2^27 at DEC = 512).
  - If c3 >= 2^OUT_W, data_out = 2^OUT_W - 1 (saturate; all-ones input case).
  - Otherwise data_out = c3[OUT_W-1:0].
- Start-up transient: the first 3 load pulses after reset carry filter transient. From the 4th pulse onward data_out is exact for the stationary input.
- mod_valid timing independence: results depend only on the sequence of sampled bits, not on strobe spacing (2 clk or sparse).
- The block has no knowledge of cs_n. The downstream stage ignores load while a frame is active.

Test Plan:
- Reset: assert rst for 3 cycles during activity -> data_out = 0, load = 0 in the cycle after rst deasserts; no spurious load pulse until 512 further strobes have been seen.
- All-zeros: 4*512 strobes with mod_in = 0 -> 4 load pulses, each 1 cycle wide, every data_out = 0.
- All-ones: 5*512 strobes with mod_in = 1 -> 4th and 5th data_out = 0x7FFFFFF (saturated).
- Alternating 1,0: 5*512 strobes -> 4th and 5th data_out = 0x4000000.
- Latency/spacing: strobes every 2 clk, then every 37 clk, with mod_in pattern 1,1,0 repeating:
  - load occurs exactly 5 clk after every 512th strobe;
  - data_out matches the bit-accurate reference model regardless of spacing.
- Reset mid-comb: assert rst for 1 cycle during COMB2 -> no load pulse for that window; the next window restarts the transient, giving 0 for an all-zeros input.
